// File: rtl/tx_turn_mem_wr.sv
// TRN TX memory-write issuer: latches one write request, waits for an arbiter turn,
// then emits a single 2-DW MWr TLP. Optional build macro ADDR32_HDR_EN enables 3DW headers.
module tx_turn_mem_wr #(
    parameter logic [7:0] TAG_BASE = 8'h00
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        tx_turn,
    output logic        tx_driven,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [15:0] cfg_completer_id,
    input  logic        trn_tbuf_av_p,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    output logic        done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BEAT0   = 3'd1;
    localparam logic [2:0] S_BEAT1   = 3'd2;
    localparam logic [2:0] S_BEAT2   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        pending_q, pending_d;
    logic [7:0]  tag_q, tag_d;
    logic        hdr3_q, hdr3_d;
    logic        tx_driven_q, tx_driven_d;
    logic        req_ready_q, req_ready_d;
    logic        done_q, done_d;
    logic [63:0] td_q, td_d;
    logic [7:0]  trem_n_q, trem_n_d;
    logic        tsof_n_q, tsof_n_d;
    logic        teof_n_q, teof_n_d;
    logic        tsrc_rdy_n_q, tsrc_rdy_n_d;

    // Request payload registers carry no reset; pending_q qualifies them.
    logic [63:3] addr_q;
    logic [63:0] data_q;

    logic accept;
    logic beat_ack;
    logic use_hdr3;
    logic addr_lsb_unused;

    // Sub-QW address bits are never used: the TLP is always QW aligned.
    assign addr_lsb_unused = ^req_addr[2:0];

    assign accept   = req_valid && req_ready_q;
    assign beat_ack = !trn_tdst_rdy_n;

`ifdef ADDR32_HDR_EN
    assign use_hdr3 = (addr_q[63:32] == 32'h0000_0000);
`else
    assign use_hdr3 = 1'b0;
`endif

    // DW0: fmt, type, TC/TD/EP/attr zero, two-DW payload.
    function automatic logic [31:0] hdr_dw0(input logic hdr3);
        logic [1:0] fmt;
        fmt = hdr3 ? 2'b10 : 2'b11;
        return {1'b0, fmt, 5'b00000, 1'b0, 3'b000, 4'b0000,
                1'b0, 1'b0, 2'b00, 2'b00, 10'd2};
    endfunction

    function automatic logic [31:0] hdr_dw1(input logic [15:0] req_id,
                                            input logic [7:0]  tag);
        return {req_id, tag, 4'hF, 4'hF};
    endfunction

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        tag_d        = tag_q;
        hdr3_d       = hdr3_q;
        tx_driven_d  = tx_driven_q;
        done_d       = 1'b0;
        td_d         = td_q;
        trem_n_d     = trem_n_q;
        tsof_n_d     = tsof_n_q;
        teof_n_d     = teof_n_q;
        tsrc_rdy_n_d = tsrc_rdy_n_q;

        if (accept) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_turn && pending_q && trn_tbuf_av_p) begin
                    state_d      = S_BEAT0;
                    tx_driven_d  = 1'b1;
                    hdr3_d       = use_hdr3;
                    td_d         = {hdr_dw0(use_hdr3), hdr_dw1(cfg_completer_id, tag_q)};
                    trem_n_d     = 8'h00;
                    tsof_n_d     = 1'b0;
                    teof_n_d     = 1'b1;
                    tsrc_rdy_n_d = 1'b0;
                end
            end
            S_BEAT0: begin
                if (beat_ack) begin
                    state_d  = S_BEAT1;
                    tsof_n_d = 1'b1;
                    if (hdr3_q) begin
                        td_d = {addr_q[31:3], 3'b000, data_q[31:0]};
                    end else begin
                        td_d = {addr_q[63:32], addr_q[31:3], 3'b000};
                    end
                end
            end
            S_BEAT1: begin
                if (beat_ack) begin
                    state_d  = S_BEAT2;
                    teof_n_d = 1'b0;
                    if (hdr3_q) begin
                        td_d     = {data_q[63:32], 32'h0000_0000};
                        trem_n_d = 8'h0F;
                    end else begin
                        td_d     = {data_q[31:0], data_q[63:32]};
                        trem_n_d = 8'h00;
                    end
                end
            end
            S_BEAT2: begin
                if (beat_ack) begin
                    state_d      = S_RELEASE;
                    pending_d    = 1'b0;
                    tag_d        = tag_q + 8'd1;
                    done_d       = 1'b1;
                    tsrc_rdy_n_d = 1'b1;
                    teof_n_d     = 1'b1;
                    trem_n_d     = 8'h00;
                end
            end
            S_RELEASE: begin
                state_d     = S_IDLE;
                tx_driven_d = 1'b0;
            end
            default: begin
                state_d      = S_IDLE;
                tx_driven_d  = 1'b0;
                tsrc_rdy_n_d = 1'b1;
                tsof_n_d     = 1'b1;
                teof_n_d     = 1'b1;
            end
        endcase

        // Ready is registered so it reads low throughout reset.
        req_ready_d = (state_d == S_IDLE) && !pending_d;
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            tag_q        <= TAG_BASE;
            hdr3_q       <= 1'b0;
            tx_driven_q  <= 1'b0;
            req_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            td_q         <= 64'h0;
            trem_n_q     <= 8'h00;
            tsof_n_q     <= 1'b1;
            teof_n_q     <= 1'b1;
            tsrc_rdy_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            tag_q        <= tag_d;
            hdr3_q       <= hdr3_d;
            tx_driven_q  <= tx_driven_d;
            req_ready_q  <= req_ready_d;
            done_q       <= done_d;
            td_q         <= td_d;
            trem_n_q     <= trem_n_d;
            tsof_n_q     <= tsof_n_d;
            teof_n_q     <= teof_n_d;
            tsrc_rdy_n_q <= tsrc_rdy_n_d;
        end
    end

    always_ff @(posedge trn_clk) begin
        if (accept) begin
            addr_q <= req_addr[63:3];
            data_q <= req_data;
        end
    end

    assign tx_driven      = tx_driven_q;
    assign req_ready      = req_ready_q;
    assign done           = done_q;
    assign trn_td         = td_q;
    assign trn_trem_n     = trem_n_q;
    assign trn_tsof_n     = tsof_n_q;
    assign trn_teof_n     = teof_n_q;
    assign trn_tsrc_rdy_n = tsrc_rdy_n_q;

endmodule

// File: tb/tb_tx_turn_mem_wr.sv
// Directed bench for tx_turn_mem_wr; define ADDR32_HDR_EN on both files to cover 3DW headers.
module tb_tx_turn_mem_wr;

    localparam logic [7:0]  TB_TAG_BASE = 8'hA5;
    localparam logic [15:0] CID         = 16'h0100;
    localparam logic [31:0] DW0_4DW     = 32'h6000_0002;
    localparam logic [31:0] DW0_3DW     = 32'h4000_0002;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        tx_turn = 1'b0;
    logic        tx_driven;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_data = 64'h0;
    logic        tbuf_av = 1'b1;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        tdst_rdy_n = 1'b0;
    logic        done;

    int          vectors = 0;
    int          errors = 0;
    logic [7:0]  exp_tag;

    always #5 clk = ~clk;

    tx_turn_mem_wr #(.TAG_BASE(TB_TAG_BASE)) dut (
        .trn_clk          (clk),
        .reset_n          (reset_n),
        .tx_turn          (tx_turn),
        .tx_driven        (tx_driven),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .cfg_completer_id (CID),
        .trn_tbuf_av_p    (tbuf_av),
        .trn_td           (trn_td),
        .trn_trem_n       (trn_trem_n),
        .trn_tsof_n       (trn_tsof_n),
        .trn_teof_n       (trn_teof_n),
        .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n   (tdst_rdy_n),
        .done             (done)
    );

    // Offers one request starting at a negedge; returns whether it was accepted.
    task automatic submit(input logic [63:0] a, input logic [63:0] d, output logic ok);
        int n;
        n = 0;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Pulses a turn with the core always ready and records the three beats and handshake.
    task automatic run_tlp(output logic [63:0] b0, output logic [63:0] b1,
                           output logic [63:0] b2, output logic [7:0] rem2,
                           output logic ok);
        tx_turn = 1'b1;
        @(negedge clk);
        tx_turn = 1'b0;
        ok = (tx_driven === 1'b1) && (trn_tsof_n === 1'b0) && (trn_tsrc_rdy_n === 1'b0);
        b0 = trn_td;
        @(negedge clk);
        ok = ok && (trn_tsof_n === 1'b1) && (trn_teof_n === 1'b1);
        b1 = trn_td;
        @(negedge clk);
        ok = ok && (trn_teof_n === 1'b0);
        b2 = trn_td;
        rem2 = trn_trem_n;
        @(negedge clk);
        ok = ok && (done === 1'b1) && (trn_tsrc_rdy_n === 1'b1) && (tx_driven === 1'b1);
        @(negedge clk);
        ok = ok && (done === 1'b0) && (tx_driven === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({tx_driven, req_ready, done, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n} !== 6'b000111) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000111",
                     {tx_driven, req_ready, done, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n});
        end
        vectors++;
        if (trn_td !== 64'h0 || trn_trem_n !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: td %h trem %h want 0/00", trn_td, trn_trem_n);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_ready: got %b want 0", req_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || tx_driven !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready %b driven %b want 1/0", req_ready, tx_driven);
        end
        exp_tag = TB_TAG_BASE;
    endtask

    task automatic test_single_tlp();
        logic ok;
        submit(64'h1_0000_1000, 64'hBBBBBBBB_AAAAAAAA, ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got %b want 1", ok);
        end
        vectors++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_pending: got %b want 0", req_ready);
        end
        tx_turn = 1'b1;
        @(negedge clk);
        tx_turn = 1'b0;
        vectors++;
        if ({tx_driven, trn_tsof_n, trn_tsrc_rdy_n, trn_teof_n} !== 4'b1001) begin
            errors++;
            $display("FAIL single_beat0_ctrl: got %b want 1001",
                     {tx_driven, trn_tsof_n, trn_tsrc_rdy_n, trn_teof_n});
        end
        vectors++;
        if (trn_td !== {DW0_4DW, CID, exp_tag, 8'hFF}) begin
            errors++;
            $display("FAIL single_beat0_td: got %h want %h", trn_td, {DW0_4DW, CID, exp_tag, 8'hFF});
        end
        @(negedge clk);
        vectors++;
        if (trn_td !== 64'h00000001_00001000 || trn_tsof_n !== 1'b1 || trn_teof_n !== 1'b1) begin
            errors++;
            $display("FAIL single_beat1: td %h sof %b eof %b want 0000000100001000/1/1",
                     trn_td, trn_tsof_n, trn_teof_n);
        end
        @(negedge clk);
        vectors++;
        if (trn_td !== 64'hAAAAAAAA_BBBBBBBB || trn_teof_n !== 1'b0 || trn_trem_n !== 8'h00) begin
            errors++;
            $display("FAIL single_beat2: td %h eof %b rem %h want AAAAAAAABBBBBBBB/0/00",
                     trn_td, trn_teof_n, trn_trem_n);
        end
        @(negedge clk);
        vectors++;
        if ({done, trn_tsrc_rdy_n, trn_teof_n, tx_driven, req_ready} !== 5'b11110) begin
            errors++;
            $display("FAIL single_release: got %b want 11110",
                     {done, trn_tsrc_rdy_n, trn_teof_n, tx_driven, req_ready});
        end
        @(negedge clk);
        vectors++;
        if ({done, tx_driven, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL single_idle: got %b want 001", {done, tx_driven, req_ready});
        end
        exp_tag = exp_tag + 8'd1;
    endtask

    task automatic test_stall();
        logic ok;
        submit(64'h0000_0003_4000_0007, 64'h87654321_12345678, ok);
        vectors++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got %b want 1", ok);
        end
        tx_turn = 1'b1;
        @(negedge clk);
        tx_turn = 1'b0;
        vectors++;
        if (trn_td !== {DW0_4DW, CID, exp_tag, 8'hFF}) begin
            errors++;
            $display("FAIL stall_tag_next: got %h want %h", trn_td, {DW0_4DW, CID, exp_tag, 8'hFF});
        end
        @(negedge clk);
        tdst_rdy_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_turn = (i == 1);
            @(negedge clk);
            vectors++;
            if (trn_td !== 64'h00000003_40000000 || trn_teof_n !== 1'b1 || trn_tsrc_rdy_n !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: td %h eof %b src %b want 0000000340000000/1/0",
                         i, trn_td, trn_teof_n, trn_tsrc_rdy_n);
            end
        end
        tx_turn = 1'b0;
        tdst_rdy_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (trn_td !== 64'h12345678_87654321 || trn_teof_n !== 1'b0) begin
            errors++;
            $display("FAIL stall_beat2: td %h eof %b want 1234567887654321/0", trn_td, trn_teof_n);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got %b want 1", done);
        end
        @(negedge clk);
        exp_tag = exp_tag + 8'd1;
    endtask

    task automatic test_turn_ignored();
        logic ok;
        logic [63:0] b0, b1, b2;
        logic [7:0] rem;
        logic saw_drive;
        saw_drive = 1'b0;
        tx_turn = 1'b1;
        @(negedge clk);
        tx_turn = 1'b0;
        repeat (3) begin
            if (tx_driven !== 1'b0 || trn_tsof_n !== 1'b1) saw_drive = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_drive !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_pending: got drive %b want 0", saw_drive);
        end
        submit(64'h0000_0000_0000_8000, 64'h0000_0002_0000_0001, ok);
        tbuf_av = 1'b0;
        tx_turn = 1'b1;
        @(negedge clk);
        tx_turn = 1'b0;
        tbuf_av = 1'b1;
        repeat (3) begin
            if (tx_driven !== 1'b0 || trn_tsof_n !== 1'b1) saw_drive = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_drive !== 1'b0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL ign_no_tbuf: drive %b accept %b want 0/1", saw_drive, ok);
        end
        run_tlp(b0, b1, b2, rem, ok);
        vectors++;
        if (ok !== 1'b1 || b0[15:8] !== exp_tag || b2 !== 64'h00000001_00000002) begin
            errors++;
            $display("FAIL ign_retry: ok %b tag %h b2 %h want 1/%h/0000000100000002",
                     ok, b0[15:8], b2, exp_tag);
        end
        exp_tag = exp_tag + 8'd1;
    endtask

    task automatic test_back_to_back();
        logic ok, acc;
        logic [63:0] b0, b1, b2;
        logic [7:0] rem;
        logic [7:0] start_tag;
        start_tag = exp_tag;
        for (int i = 0; i < 256; i++) begin
            submit({32'h0, 16'h0, i[7:0], 8'h00}, {24'h0, i[7:0], 24'h0, ~i[7:0]}, acc);
            run_tlp(b0, b1, b2, rem, ok);
            vectors++;
            if (acc !== 1'b1 || ok !== 1'b1 || b0 !== {DW0_4DW, CID, exp_tag, 8'hFF} ||
                b2 !== {24'h0, ~i[7:0], 24'h0, i[7:0]}) begin
                errors++;
                $display("FAIL b2b_%0d: acc %b ok %b b0 %h b2 %h want tag %h", i, acc, ok, b0, b2, exp_tag);
            end
            exp_tag = exp_tag + 8'd1;
        end
        submit(64'h10, 64'h0, acc);
        run_tlp(b0, b1, b2, rem, ok);
        vectors++;
        if (b0[15:8] !== start_tag) begin
            errors++;
            $display("FAIL b2b_wrap: got tag %h want %h", b0[15:8], start_tag);
        end
        exp_tag = exp_tag + 8'd1;
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [63:0] b0, b1, b2;
        logic [7:0] rem;
        logic saw_drive;
        submit(64'h0000_0005_0000_0100, 64'hCAFEF00D_DEADBEEF, ok);
        tx_turn = 1'b1;
        @(negedge clk);
        tx_turn = 1'b0;
        @(negedge clk);
        vectors++;
        if (trn_td !== 64'h00000005_00000100) begin
            errors++;
            $display("FAIL rmid_at_beat1: got %h want 0000000500000100", trn_td);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({tx_driven, req_ready, done, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n} !== 6'b000111 ||
            trn_td !== 64'h0 || trn_trem_n !== 8'h00) begin
            errors++;
            $display("FAIL rmid_async: ctrl %b td %h rem %h want 000111/0/00",
                     {tx_driven, req_ready, done, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n},
                     trn_td, trn_trem_n);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || tx_driven !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release: ready %b driven %b want 1/0", req_ready, tx_driven);
        end
        saw_drive = 1'b0;
        tx_turn = 1'b1;
        @(negedge clk);
        tx_turn = 1'b0;
        repeat (3) begin
            if (tx_driven !== 1'b0 || trn_tsof_n !== 1'b1 || done !== 1'b0) saw_drive = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_drive !== 1'b0) begin
            errors++;
            $display("FAIL rmid_residual: got drive %b want 0", saw_drive);
        end
        exp_tag = TB_TAG_BASE;
        submit(64'h0000_0000_0000_0040, 64'h0, ok);
        run_tlp(b0, b1, b2, rem, ok);
        vectors++;
        if (ok !== 1'b1 || b0[15:8] !== exp_tag) begin
            errors++;
            $display("FAIL rmid_tag_reset: ok %b tag %h want 1/%h", ok, b0[15:8], exp_tag);
        end
        exp_tag = exp_tag + 8'd1;
    endtask

    task automatic test_low_addr();
        logic ok;
        logic [63:0] b0, b1, b2;
        logic [7:0] rem;
        submit(64'h0000_0000_2000_0000, 64'h22222222_11111111, ok);
        run_tlp(b0, b1, b2, rem, ok);
`ifdef ADDR32_HDR_EN
        vectors++;
        if (ok !== 1'b1 || b0[62:61] !== 2'b10 || b0[63:32] !== DW0_3DW) begin
            errors++;
            $display("FAIL a32_dw0: ok %b dw0 %h want 1/%h", ok, b0[63:32], DW0_3DW);
        end
        vectors++;
        if (b1 !== 64'h20000000_11111111 || b2[63:32] !== 32'h22222222 || rem !== 8'h0F) begin
            errors++;
            $display("FAIL a32_beats: b1 %h b2 %h rem %h want 2000000011111111/22222222xx/0F",
                     b1, b2, rem);
        end
`else
        vectors++;
        if (ok !== 1'b1 || b0[63:32] !== DW0_4DW) begin
            errors++;
            $display("FAIL a64_dw0: ok %b dw0 %h want 1/%h", ok, b0[63:32], DW0_4DW);
        end
        vectors++;
        if (b1 !== 64'h00000000_20000000 || b2 !== 64'h11111111_22222222 || rem !== 8'h00) begin
            errors++;
            $display("FAIL a64_beats: b1 %h b2 %h rem %h want 0000000020000000/1111111122222222/00",
                     b1, b2, rem);
        end
`endif
        exp_tag = exp_tag + 8'd1;
    endtask

    initial begin
        test_reset();
        test_single_tlp();
        test_stall();
        test_turn_ignored();
        test_back_to_back();
        test_reset_mid();
        test_low_addr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
